// File: rtl/pong_pkg.sv
// pong_pkg: shared types and helpers for the Ping-Pong game objects.
//   dir_t     - per-frame movement decision (PUT = stay/stop, DEC, INC)
//   pstate_t  - paddle motion state
//   clamp_pos - limits a signed 13-bit coordinate to [lo, hi] and returns it as 12 bits
package pong_pkg;
  typedef enum logic [1:0] {PUT, DEC, INC} dir_t;
  typedef enum logic {IDLE, RUN} pstate_t;
  function automatic logic [11:0] clamp_pos(
    input logic signed [12:0] v,
    input logic signed [12:0] lo,
    input logic signed [12:0] hi
  );
    return v < lo ? lo[11:0] : v > hi ? hi[11:0] : v[11:0];
  endfunction
endpackage

// File: rtl/paddle_axis_if.sv
// paddle_axis_if: video-timing, button and render/position bundle of one paddle.
//   master: drives fsync, hpos, vpos, inc, dec; receives pixel, active, pos, at_min, at_max
//   slave : the paddle itself
interface paddle_axis_if;
  logic              fsync;
  logic signed [11:0] hpos;
  logic signed [11:0] vpos;
  logic              inc;
  logic              dec;
  logic [7:0]        pixel [0:2];
  logic              active;
  logic [11:0]       pos;
  logic              at_min;
  logic              at_max;
  modport master(output fsync, hpos, vpos, inc, dec, input pixel, active, pos, at_min, at_max);
  modport slave(input fsync, hpos, vpos, inc, dec, output pixel, active, pos, at_min, at_max);
endinterface

// File: rtl/paddle_axis_sync_3ff.sv
// sync_3ff: 1-bit three-flop synchroniser with asynchronous active-high reset.
//   clk, rst : clock and reset
//   d_i      : asynchronous input
//   q_o      : synchronised output, three clk edges after d_i
module sync_3ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [2:0] sr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr_q <= '0;
    else     sr_q <= {sr_q[1:0], d_i};
  end
  assign q_o = sr_q[2];
endmodule

// File: rtl/paddle_axis.sv
// paddle_axis: one player's paddle; moves along AXIS once per frame with
// acceleration and edge clamping, and renders itself from hpos/vpos.
//   pixel_clk, rst : clock, asynchronous active-high reset
//   bus (slave)    : fsync/hpos/vpos/inc/dec in; pixel/active/pos/at_min/at_max out
module paddle_axis
  import pong_pkg::*;
#(
  parameter int          HRES         = 1280,
  parameter int          VRES         = 720,
  parameter int          AXIS         = 0,
  parameter int          PADDLE_LEN   = 200,
  parameter int          PADDLE_THK   = 20,
  parameter int          FIXED_POS    = 0,
  parameter logic [23:0] COLOR        = 24'hEFE62E,
  parameter int          SPEED_MIN    = 1,
  parameter int          SPEED_MAX    = 8,
  parameter int          ACCEL_FRAMES = 4
) (
  input logic          pixel_clk,
  input logic          rst,
  paddle_axis_if.slave bus
);
  localparam int LIMIT = AXIS == 0 ? HRES : VRES;
  localparam int POS_MAX = LIMIT - PADDLE_LEN;
  localparam logic [11:0] POS_RST = 12'(POS_MAX / 2);
  localparam logic [11:0] PMAX12 = 12'(POS_MAX);
  localparam logic signed [12:0] PMAX13 = 13'(POS_MAX);
  localparam logic [11:0] SMIN = 12'(SPEED_MIN);
  localparam logic [11:0] SMAX = 12'(SPEED_MAX);
  localparam logic [7:0] HOLD_LAST = 8'(ACCEL_FRAMES - 1);
  localparam logic signed [13:0] LEN_M1 = 14'(PADDLE_LEN - 1);
  localparam logic signed [13:0] F_LO = 14'(FIXED_POS);
  localparam logic signed [13:0] F_HI = 14'(FIXED_POS + PADDLE_THK - 1);
  if (PADDLE_LEN > LIMIT) begin : g_len_chk
    $error("paddle_axis: PADDLE_LEN larger than screen axis");
  end
  if (SPEED_MIN > SPEED_MAX) begin : g_spd_chk
    $error("paddle_axis: SPEED_MIN above SPEED_MAX");
  end
  if (ACCEL_FRAMES < 1) begin : g_acc_chk
    $error("paddle_axis: ACCEL_FRAMES must be at least 1");
  end
  logic inc_s, dec_s;
  sync_3ff u_sync_inc (.clk(pixel_clk), .rst(rst), .d_i(bus.inc), .q_o(inc_s));
  sync_3ff u_sync_dec (.clk(pixel_clk), .rst(rst), .d_i(bus.dec), .q_o(dec_s));
  logic req_inc_q, req_dec_q;
  // The fsync-cycle sample restarts the latch, so it belongs to the next frame.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      req_inc_q <= 1'b0;
      req_dec_q <= 1'b0;
    end else begin
      req_inc_q <= inc_s | (req_inc_q & ~bus.fsync);
      req_dec_q <= dec_s | (req_dec_q & ~bus.fsync);
    end
  end
  pstate_t state_q;
  dir_t last_q, dir;
  logic [11:0] pos_q, pos_d, speed_q, speed_d, spd_base;
  logic [7:0] hold_q, hold_d, hold_base;
  logic at_min_q, at_max_q, same, wrap, clamped;
  logic signed [12:0] p13, s13, nxt;
  // A move continuing the previous direction counts toward acceleration;
  // anything else restarts from SPEED_MIN with the current move as the first.
  always_comb begin
    dir = req_inc_q == req_dec_q ? PUT : req_inc_q ? INC : DEC;
    same = state_q == RUN && dir == last_q;
    spd_base = same ? speed_q : SMIN;
    hold_base = same ? hold_q : 8'd0;
    p13 = {1'b0, pos_q};
    s13 = {1'b0, spd_base};
    nxt = dir == INC ? p13 + s13 : p13 - s13;
    clamped = dir != PUT && (nxt < 13'sd0 || nxt > PMAX13);
    pos_d = dir == PUT ? pos_q : clamp_pos(nxt, 13'sd0, PMAX13);
    wrap = hold_base == HOLD_LAST;
    hold_d = wrap ? 8'd0 : hold_base + 8'd1;
    speed_d = wrap && spd_base < SMAX ? spd_base + 12'd1 : spd_base;
  end
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= PUT;
      pos_q    <= POS_RST;
      speed_q  <= SMIN;
      hold_q   <= 8'd0;
      at_min_q <= 1'b0;
      at_max_q <= 1'b0;
    end else if (bus.fsync) begin
      pos_q    <= pos_d;
      at_min_q <= pos_d == 12'd0;
      at_max_q <= pos_d == PMAX12;
      if (dir == PUT || clamped) begin
        state_q <= IDLE;
        speed_q <= SMIN;
        hold_q  <= 8'd0;
      end else begin
        state_q <= RUN;
        last_q  <= dir;
        speed_q <= speed_d;
        hold_q  <= hold_d;
      end
    end
  end
  logic signed [13:0] m, f, p;
  logic act;
  always_comb begin
    m = AXIS == 0 ? 14'(bus.hpos) : 14'(bus.vpos);
    f = AXIS == 0 ? 14'(bus.vpos) : 14'(bus.hpos);
    p = {2'b00, pos_q};
    act = m >= p && m <= p + LEN_M1 && f >= F_LO && f <= F_HI;
  end
  assign bus.active   = act;
  assign bus.pixel[0] = act ? COLOR[7:0] : 8'h00;
  assign bus.pixel[1] = act ? COLOR[15:8] : 8'h00;
  assign bus.pixel[2] = act ? COLOR[23:16] : 8'h00;
  assign bus.pos      = pos_q;
  assign bus.at_min   = at_min_q;
  assign bus.at_max   = at_max_q;
endmodule

// File: tb/tb_paddle_axis.sv
// tb_paddle_axis: scoreboard bench for a horizontal and a vertical paddle.
module tb_paddle_axis;
  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst = 1'b1;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end
  paddle_axis_if bh ();
  paddle_axis_if bv ();
  paddle_axis dut_h (.pixel_clk(clk), .rst(rst), .bus(bh));
  paddle_axis #(.AXIS(1), .FIXED_POS(1240)) dut_v (.pixel_clk(clk), .rst(rst), .bus(bv));
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {int pos; int amin; int amax;} exp_t;
  exp_t qh[$];
  exp_t qv[$];
  int mpos[2] = '{540, 260};
  int mrun[2] = '{0, 0};
  int mlast[2] = '{0, 0};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  function automatic int pos_max(input int k);
    return k ? 720 - 200 : 1280 - 200;
  endfunction
  // Speed of the n-th consecutive move in one direction: +1 every 4 moves, capped at 8.
  function automatic void model_step(input int k, input int d);
    int sp, np;
    exp_t e;
    if (d == 0) mrun[k] = 0;
    else begin
      mrun[k] = (mrun[k] > 0 && mlast[k] == d) ? mrun[k] + 1 : 1;
      sp = 1 + (mrun[k] - 1) / 4;
      if (sp > 8) sp = 8;
      np = mpos[k] + d * sp;
      if (np < 0) begin np = 0; mrun[k] = 0; end
      if (np > pos_max(k)) begin np = pos_max(k); mrun[k] = 0; end
      mpos[k] = np;
      mlast[k] = d;
    end
    e.pos = mpos[k];
    e.amin = int'(mpos[k] == 0);
    e.amax = int'(mpos[k] == pos_max(k));
    if (k == 0) qh.push_back(e);
    else qv.push_back(e);
  endfunction
  function automatic int rend(input int axis, input int pos, input int fixed, input int h, input int v);
    int m, f;
    m = axis ? v : h;
    f = axis ? h : v;
    return int'(m >= pos && m < pos + 200 && f >= fixed && f < fixed + 20);
  endfunction
  function automatic int dirv(input bit i, input bit d);
    return i == d ? 0 : i ? 1 : -1;
  endfunction
  logic pend;
  always @(posedge clk or posedge rst) pend <= rst ? 1'b0 : bh.fsync;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (qh.size() == 0) chk("h_unexpected_update", 1, 0);
      else begin
        e = qh.pop_front();
        chk("h_pos", bh.pos, e.pos);
        chk("h_at_min", bh.at_min, e.amin);
        chk("h_at_max", bh.at_max, e.amax);
      end
      if (qv.size() == 0) chk("v_unexpected_update", 1, 0);
      else begin
        e = qv.pop_front();
        chk("v_pos", bv.pos, e.pos);
        chk("v_at_min", bv.at_min, e.amin);
        chk("v_at_max", bv.at_max, e.amax);
      end
    end
  end
  // Buttons are held then released well before fsync so each frame carries one request set.
  task automatic frame(input bit ih, input bit dh, input bit iv, input bit dv);
    bh.inc = ih; bh.dec = dh; bv.inc = iv; bv.dec = dv;
    repeat (8) @(negedge clk);
    bh.inc = 0; bh.dec = 0; bv.inc = 0; bv.dec = 0;
    repeat (8) @(negedge clk);
    model_step(0, dirv(ih, dh));
    model_step(1, dirv(iv, dv));
    bh.fsync = 1; bv.fsync = 1;
    @(negedge clk);
    bh.fsync = 0; bv.fsync = 0;
  endtask
  task automatic rchk_h(input string name, input int h, input int v);
    int a;
    bh.hpos = 12'(h); bh.vpos = 12'(v);
    #1;
    a = rend(0, mpos[0], 0, h, v);
    chk(name, bh.active, a);
    chk({name, "_pix"}, {bh.pixel[2], bh.pixel[1], bh.pixel[0]}, a ? 24'hEFE62E : 24'h0);
  endtask
  task automatic rchk_v(input string name, input int h, input int v);
    int a;
    bv.hpos = 12'(h); bv.vpos = 12'(v);
    #1;
    a = rend(1, mpos[1], 1240, h, v);
    chk(name, bv.active, a);
    chk({name, "_pix"}, {bv.pixel[2], bv.pixel[1], bv.pixel[0]}, a ? 24'hEFE62E : 24'h0);
  endtask
  initial begin
    int prev, r;
    int acc_tbl[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
    bit ih, dh, iv, dv;
    bh.fsync = 0; bh.inc = 0; bh.dec = 0; bh.hpos = 0; bh.vpos = 0;
    bv.fsync = 0; bv.inc = 0; bv.dec = 0; bv.hpos = 0; bv.vpos = 0;
    repeat (3) @(negedge clk);
    chk("rst_h_pos", bh.pos, 540);
    chk("rst_v_pos", bv.pos, 260);
    chk("rst_h_flags", {bh.at_min, bh.at_max}, 0);
    chk("rst_v_flags", {bv.at_min, bv.at_max}, 0);
    rchk_h("r540", 540, 0);
    chk("r540_blue", bh.pixel[0], 8'h2E);
    chk("r540_red", bh.pixel[2], 8'hEF);
    rchk_h("r739", 739, 0);
    rchk_h("r739_f19", 739, 19);
    rchk_h("r740", 740, 0);
    rchk_h("r539", 539, 0);
    rchk_h("r540_f20", 540, 20);
    rchk_v("rv_x1240", 1240, 260);
    rchk_v("rv_x1259", 1259, 459);
    rchk_v("rv_x1260", 1260, 300);
    rchk_v("rv_x1239", 1239, 300);
    @(negedge clk);
    rst = 0;
    model_step(0, 0);
    model_step(1, 0);
    bh.fsync = 1; bv.fsync = 1;
    @(negedge clk);
    bh.fsync = 0; bv.fsync = 0;
    for (int i = 0; i < 10; i++) begin
      prev = int'(bh.pos);
      frame(1, 0, 0, 0);
      chk("accel_disp", int'(bh.pos) - prev, acc_tbl[i]);
    end
    chk("accel_total", bh.pos, 558);
    frame(1, 1, 0, 0);
    chk("conflict_hold", bh.pos, 558);
    for (int i = 0; i < 6; i++) begin
      prev = int'(bh.pos);
      frame(1, 0, 0, 0);
      if (i == 0) chk("post_conflict_disp", int'(bh.pos) - prev, 1);
    end
    prev = int'(bh.pos);
    frame(0, 1, 0, 0);
    chk("reverse_disp", int'(bh.pos) - prev, -1);
    frame(0, 0, 0, 0);
    while (mpos[0] < 1054) begin
      r = 1054 - mpos[0];
      if (r >= 40) repeat (16) frame(1, 0, 0, 0);
      else frame(1, 0, 0, 0);
      frame(0, 0, 0, 0);
    end
    repeat (12) frame(1, 0, 0, 0);
    chk("pre_clamp_pos", bh.pos, 1078);
    frame(1, 0, 0, 0);
    chk("clamp_pos", bh.pos, 1080);
    chk("clamp_at_max", bh.at_max, 1);
    frame(1, 0, 0, 0);
    chk("edge_hold_pos", bh.pos, 1080);
    frame(0, 1, 0, 0);
    chk("leave_edge_pos", bh.pos, 1079);
    chk("leave_edge_at_max", bh.at_max, 0);
    repeat (50) frame(0, 0, 0, 1);
    chk("v_edge_pos", bv.pos, 0);
    chk("v_edge_at_min", bv.at_min, 1);
    rchk_v("rv_edge_y0", 1240, 0);
    rchk_v("rv_edge_y199", 1259, 199);
    rchk_v("rv_edge_y200", 1250, 200);
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      ih = r < 4 || r == 7; dh = (r >= 4 && r <= 7);
      r = int'($urandom_range(0, 9));
      iv = r < 4 || r == 7; dv = (r >= 4 && r <= 7);
      frame(ih, dh, iv, dv);
      if (i % 10 == 0) rchk_h("rand_render", mpos[0] + int'($urandom_range(0, 220)) - 10, int'($urandom_range(0, 25)));
    end
    repeat (2) @(negedge clk);
    chk("h_queue_drained", qh.size(), 0);
    chk("v_queue_drained", qv.size(), 0);
    #1;
    clk_en = 0;
    bh.hpos = 12'(mpos[0]); bh.vpos = 0;
    #3;
    rst = 1;
    #1;
    mpos[0] = 540;
    mpos[1] = 260;
    chk("async_h_pos", bh.pos, 540);
    chk("async_v_pos", bv.pos, 260);
    chk("async_h_flags", {bh.at_min, bh.at_max}, 0);
    chk("async_v_flags", {bv.at_min, bv.at_max}, 0);
    chk("async_active", bh.active, rend(0, 540, 0, int'(bh.hpos), 0));
    chk("async_pixel", {bh.pixel[2], bh.pixel[1], bh.pixel[0]}, rend(0, 540, 0, int'(bh.hpos), 0) ? 24'hEFE62E : 24'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
